// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared state encoding and slice helpers for alu_share_arbiter
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MAX_REQ = 8;

  // Bit offset of requester k's slice in a packed per-requester bus of width w.
  function automatic int slice_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// rtl/alu_share_arbiter_rr_pick.sv - combinational round-robin selector
module alu_share_arbiter_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] k;

  // Scan last+1, last+2, ... modulo N_REQ; the first asserted request wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    k    = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      sum = {1'b0, last} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      k = sum[IDX_W-1:0];
      if (!any && req[k]) begin
        pick[k] = 1'b1;
        idx     = k;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one external function unit between requesters
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 2,
  parameter int INSTR_W = 2,
  parameter int ID_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    a_in,
  input  logic [N_REQ*DATA_W-1:0]    b_in,
  input  logic [N_REQ*INSTR_W-1:0]   i_in,
  output logic [N_REQ-1:0]           grant,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [INSTR_W-1:0]         alu_i,
  input  logic [DATA_W-1:0]          alu_f,
  output logic                       res_valid,
  output logic [DATA_W-1:0]          res_data,
  output logic [ID_W-1:0]            res_id,
  input  logic                       res_ready,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   win;
  logic [N_REQ-1:0]   pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [INSTR_W-1:0] sel_i;

  alu_share_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Operand mux driven by the one-hot pick so the slice bases stay constant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_i = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick[k]) begin
        sel_a = a_in[slice_off(k, DATA_W) +: DATA_W];
        sel_b = b_in[slice_off(k, DATA_W) +: DATA_W];
        sel_i = i_in[slice_off(k, INSTR_W) +: INSTR_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_i     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      busy      <= 1'b0;
      last      <= IDX_W'(N_REQ - 1);
      win       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            alu_a <= sel_a;
            alu_b <= sel_b;
            alu_i <= sel_i;
            grant <= pick;
            win   <= pick_idx;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        // alu_* have been stable for a full cycle, so alu_f has settled.
        EXEC: begin
          res_data  <= alu_f;
          res_id    <= ID_W'(win);
          res_valid <= 1'b1;
          grant     <= '0;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            last      <= win;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          grant     <= '0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with an A^B^I function unit stub
module tb_alu_share_arbiter;

  localparam int N   = 3;
  localparam int DW  = 2;
  localparam int IW  = 2;
  localparam int IDW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] a_in = '0;
  logic [N*DW-1:0] b_in = '0;
  logic [N*IW-1:0] i_in = '0;
  logic [N-1:0]    grant;
  logic [DW-1:0]   alu_a, alu_b, alu_f, res_data;
  logic [IW-1:0]   alu_i;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic            busy;
  logic [IDW-1:0]  res_id;

  assign alu_f = alu_a ^ alu_b ^ alu_i;

  alu_share_arbiter #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .INSTR_W (IW),
    .ID_W    (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .i_in      (i_in),
    .grant     (grant),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_i     (alu_i),
    .alu_f     (alu_f),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] gseq[$];
  int           gcyc[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           g0       = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [IW-1:0] i);
    a_in[k*DW +: DW] = a;
    b_in[k*DW +: DW] = b;
    i_in[k*IW +: IW] = i;
  endtask

  task automatic push(input int id, input int data);
    exp_t e;
    e.id   = IDW'(id);
    e.data = DW'(data);
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Drop each requester once its grant is seen; stop when everything has drained.
  task automatic idle_wait(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (grant != '0) gseq.push_back(grant);
      done = (req == '0) && !busy && !res_valid;
      #1 req = req & ~grant;
    end
    check({name, "_drain"}, 32'(done), 32'd1);
  endtask

  // Monitor: samples after the stimulus drive point and before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_unexpected: got id %0d data %0d expected no result", res_id, res_data);
          end else begin
            e = sb.pop_front();
            check("res_id", 32'(res_id), 32'(e.id));
            check("res_data", 32'(res_data), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    #1 rst = 1'b0;

    // T1: single request, F = 3^1^2 = 0
    set_op(0, 2'd3, 2'd1, 2'd2);
    req = 3'b001;
    push(0, 0);
    @(negedge clk);
    check("t1_grant", 32'(grant), 32'b001);
    check("t1_alu_a", 32'(alu_a), 32'd3);
    check("t1_alu_b", 32'(alu_b), 32'd1);
    check("t1_alu_i", 32'(alu_i), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);
    #1 req = '0;
    @(negedge clk);
    check("t1_valid", 32'(res_valid), 32'd1);
    check("t1_data", 32'(res_data), 32'd0);
    check("t1_id", 32'(res_id), 32'd0);
    @(negedge clk);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_valid_done", 32'(res_valid), 32'd0);

    // T2: simultaneous requests after reset, requester 0 first
    pulse_reset();
    set_op(0, 2'd1, 2'd0, 2'd0);
    set_op(1, 2'd2, 2'd3, 2'd1);
    req = 3'b011;
    push(0, 1);
    push(1, 0);
    gseq.delete();
    idle_wait("t2");
    check("t2_ngrants", 32'(gseq.size()), 32'd2);
    check("t2_grant0", 32'(gseq[0]), 32'b001);
    check("t2_grant1", 32'(gseq[1]), 32'b010);

    // T3: all three held -> 001,010,100,001 every 3 cycles
    pulse_reset();
    set_op(0, 2'd1, 2'd2, 2'd0);
    set_op(1, 2'd2, 2'd3, 2'd1);
    set_op(2, 2'd3, 2'd3, 2'd2);
    req = 3'b111;
    push(0, 3);
    push(1, 0);
    push(2, 2);
    push(0, 3);
    gseq.delete();
    gcyc.delete();
    for (int c = 0; c < 30 && gseq.size() < 4; c++) begin
      @(negedge clk);
      if (grant != '0) begin
        gseq.push_back(grant);
        gcyc.push_back(cyc);
      end
    end
    #1 req = '0;
    idle_wait("t3");
    check("t3_ngrants", 32'(gseq.size()), 32'd4);
    check("t3_grant0", 32'(gseq[0]), 32'b001);
    check("t3_grant1", 32'(gseq[1]), 32'b010);
    check("t3_grant2", 32'(gseq[2]), 32'b100);
    check("t3_grant3", 32'(gseq[3]), 32'b001);
    for (int i = 1; i < 4; i++) check("t3_interval", 32'(gcyc[i] - gcyc[i-1]), 32'd3);

    // T4: consumer stalls 5 cycles in RESP, F = 1^1^3 = 3
    res_ready = 1'b0;
    set_op(1, 2'd1, 2'd1, 2'd3);
    req = 3'b010;
    push(1, 3);
    @(negedge clk);
    check("t4_grant", 32'(grant), 32'b010);
    #1 req = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_valid", 32'(res_valid), 32'd1);
      check("t4_data", 32'(res_data), 32'd3);
      check("t4_id", 32'(res_id), 32'd1);
      check("t4_nogrant", 32'(grant), 32'd0);
      check("t4_busy", 32'(busy), 32'd1);
    end
    #1 res_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_drop", 32'(res_valid), 32'd0);

    // T5: asynchronous reset during EXEC, then requester 1 alone
    set_op(0, 2'd2, 2'd1, 2'd1);
    req = 3'b001;
    @(negedge clk);
    check("t5_grant_pre", 32'(grant), 32'b001);
    #1 rst = 1'b1;
    req = '0;
    #1;
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_alu_a", 32'(alu_a), 32'd0);
    check("t5_alu_b", 32'(alu_b), 32'd0);
    check("t5_alu_i", 32'(alu_i), 32'd0);
    check("t5_valid", 32'(res_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    set_op(1, 2'd2, 2'd0, 2'd0);
    req = 3'b010;
    push(1, 2);
    gseq.delete();
    idle_wait("t5");
    check("t5_ngrants", 32'(gseq.size()), 32'd1);
    check("t5_grant1", 32'(gseq[0]), 32'b010);

    // T6: req0 raised and withdrawn while busy -> never granted
    res_ready = 1'b0;
    set_op(1, 2'd3, 2'd0, 2'd0);
    req = 3'b010;
    push(1, 3);
    g0 = 0;
    @(negedge clk);
    check("t6_grant", 32'(grant), 32'b010);
    #1 req = 3'b001;
    @(negedge clk);
    if (grant[0]) g0++;
    #1 req = '0;
    repeat (3) begin
      @(negedge clk);
      if (grant[0]) g0++;
    end
    #1 res_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (grant[0]) g0++;
    end
    check("t6_no_grant0", 32'(g0), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
